mac_frame_scheduler: RTL and testbench

Round-robin scheduler that shares one MAC/MII frame generator (mac_mii_top) between NUM_REQ frame requesters. It selects a requester and muxes that requester's header fields onto the generator inputs. It issues the single-cycle start pulse and waits for the generator's frame-done indication. It then enforces a programmable inter-packet gap before the next grant.

---
 rtl/mac_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mac_frame_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_scheduler.sv
// Round-robin arbiter sharing one MAC/MII frame generator between
// NUM_REQ requesters: grant, start pulse, wait for done, then an
// inter-packet gap before the next grant.
// Ports: clk, i_rst_n (async low); i_enable, i_req, packed per-slot
// header fields, i_gen_done in; o_start, o_ack, muxed fields,
// o_grant_idx, o_busy, o_frame_cnt out.
// Optional macro MAC_SCHED_TIMEOUT_EN adds a BUSY watchdog and the
// o_timeout pulse output.
module mac_frame_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int IDX_W          = 2,
   parameter int IPG_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic [NUM_REQ-1:0]    i_req,
   input  logic [48*NUM_REQ-1:0] i_dest_address,
   input  logic [48*NUM_REQ-1:0] i_src_address,
   input  logic [16*NUM_REQ-1:0] i_eth_type,
   input  logic [16*NUM_REQ-1:0] i_payload_length,
   input  logic                  i_gen_done,
   output logic                  o_start,
   output logic [47:0]           o_dest_address,
   output logic [47:0]           o_src_address,
   output logic [15:0]           o_eth_type,
   output logic [15:0]           o_payload_length,
   output logic [IDX_W-1:0]      o_grant_idx,
   output logic [NUM_REQ-1:0]    o_ack,
   output logic                  o_busy,
`ifdef MAC_SCHED_TIMEOUT_EN
   output logic                  o_timeout,
`endif
   output logic [15:0]           o_frame_cnt
);

   localparam int IPG_W =
      (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   if (IDX_W != $clog2(NUM_REQ) || IPG_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("mac_frame_scheduler: bad parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE, S_START, S_BUSY, S_IPG
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   grant_q;
   logic [IPG_W-1:0]   ipg_q, ipg_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               busy_q;
   logic [47:0]        dest_q, src_q;
   logic [15:0]        type_q, len_q;
   logic [IDX_W-1:0]   pick;
   logic               found;
   logic               grant_en;
   logic               wd_expire;

   // First requester at or above the RR pointer, wrapping.
   always_comb begin
      int unsigned j;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_q) + k) % NUM_REQ;
         if (!found && i_req[j]) begin
            found = 1'b1;
            pick  = IDX_W'(j);
         end
      end
   end

   assign grant_en = (state_q == S_IDLE) && i_enable && found;

`ifdef MAC_SCHED_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT_CYCLES) > 13) ?
                         $clog2(TIMEOUT_CYCLES) : 13;
   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   assign wd_expire = (state_q == S_BUSY) &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= (state_q == S_BUSY) ? wd_q + 1'b1 : '0;
         timeout_q <= wd_expire && !i_gen_done;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (grant_en) state_d = S_START;
         S_START: state_d = S_BUSY;
         S_BUSY:  if (i_gen_done || wd_expire) state_d = S_IPG;
         S_IPG:   if (ipg_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rr_d  = rr_q;
      ipg_d = ipg_q;
      cnt_d = cnt_q;
      if (state_q == S_START)
         rr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ?
                '0 : grant_q + 1'b1;
      if (state_q == S_BUSY && state_d == S_IPG)
         ipg_d = IPG_W'(IPG_CYCLES - 1);
      else if (state_q == S_IPG && ipg_q != '0)
         ipg_d = ipg_q - 1'b1;
      if (state_q == S_BUSY && i_gen_done)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_q    <= '0;
         ipg_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         dest_q  <= '0;
         src_q   <= '0;
         type_q  <= '0;
         len_q   <= '0;
      end else begin
         rr_q  <= rr_d;
         ipg_q <= ipg_d;
         cnt_q <= cnt_d;
         if (grant_en) begin
            grant_q <= pick;
            dest_q  <= i_dest_address[48*pick +: 48];
            src_q   <= i_src_address[48*pick +: 48];
            type_q  <= i_eth_type[16*pick +: 16];
            len_q   <= i_payload_length[16*pick +: 16];
         end
      end
   end

   always_comb begin
      o_start = (state_q == S_START);
      o_ack   = o_start ? (NUM_REQ'(1) << grant_q) : '0;
   end

   assign o_busy           = busy_q;
   assign o_grant_idx      = grant_q;
   assign o_dest_address   = dest_q;
   assign o_src_address    = src_q;
   assign o_eth_type       = type_q;
   assign o_payload_length = len_q;
   assign o_frame_cnt      = cnt_q;

endmodule

// File: tb/tb_mac_frame_scheduler.sv
// Self-checking bench for mac_frame_scheduler (default build).
// Cycle model plus directed literal checks.
module tb_mac_frame_scheduler;
   localparam int N   = 4;
   localparam int IPG = 12;

   logic          clk = 1'b0;
   logic          rst_n, en, done;
   logic [N-1:0]  req;
   logic [191:0]  dest, src;
   logic [63:0]   et, len;
   logic          o_start, o_busy;
   logic [47:0]   o_dest, o_src;
   logic [15:0]   o_et, o_len, o_cnt;
   logic [1:0]    o_grant;
   logic [N-1:0]  o_ack;
`ifdef MAC_SCHED_TIMEOUT_EN
   logic          o_timeout;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   mac_frame_scheduler #(
      .NUM_REQ(N), .IDX_W(2), .IPG_CYCLES(IPG),
      .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_req(req),
      .i_dest_address(dest), .i_src_address(src),
      .i_eth_type(et), .i_payload_length(len),
      .i_gen_done(done), .o_start(o_start),
      .o_dest_address(o_dest), .o_src_address(o_src),
      .o_eth_type(o_et), .o_payload_length(o_len),
      .o_grant_idx(o_grant), .o_ack(o_ack), .o_busy(o_busy),
`ifdef MAC_SCHED_TIMEOUT_EN
      .o_timeout(o_timeout),
`endif
      .o_frame_cnt(o_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // Behavioural model: frame phases tracked as a start flag,
   // an awaiting-done flag and a remaining gap length.
   bit          m_start, m_wait;
   int          m_gap, m_last, m_g;
   logic [15:0] m_cnt;
   logic [47:0] m_dest, m_src;
   logic [15:0] m_et, m_len;

   task automatic model_reset();
      m_start = 0; m_wait = 0; m_gap = 0; m_last = N - 1;
      m_g = 0; m_cnt = 0; m_dest = 0; m_src = 0;
      m_et = 0; m_len = 0;
   endtask

   function automatic int next_pick();
      for (int k = 1; k <= N; k++)
         if (req[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction

   task automatic model_step();
      int p;
      if (m_start) begin
         m_start = 0; m_wait = 1;
      end else if (m_wait) begin
         if (done) begin
            m_cnt++; m_wait = 0; m_gap = IPG;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (en) begin
         p = next_pick();
         if (p >= 0) begin
            m_start = 1; m_g = p; m_last = p;
            m_dest = dest[48*p +: 48]; m_src = src[48*p +: 48];
            m_et = et[16*p +: 16]; m_len = len[16*p +: 16];
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      else begin
         chk("m_start", o_start, m_start);
         chk("m_ack", o_ack, m_start ? 4'(1 << m_g) : 4'd0);
         chk("m_busy", o_busy,
             m_start || m_wait || (m_gap > 0));
         chk("m_grant", o_grant, m_g);
         chk("m_dest", o_dest, m_dest);
         chk("m_src", o_src, m_src);
         chk("m_type", o_et, m_et);
         chk("m_len", o_len, m_len);
         chk("m_cnt", o_cnt, m_cnt);
         model_step();
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int lim, output int c,
                             output bit ok);
      ok = 0; c = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (o_start) begin
            ok = 1; c = cyc; break;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      tick(2);
      rst_n = 1;
   endtask

   task automatic pulse_done();
      done = 1; tick(1); done = 0;
   endtask

   int  c, t0;
   bit  ok;
   int  st[5];
   int  gr[5];
   int  fc[5];
   int  exp_gr[5] = '{0, 1, 2, 3, 0};
   int  nst;

   initial begin
      rst_n = 0; en = 0; req = 0; done = 0;
      dest = {48'hD3D3D3D3D3D3, 48'hD2D2D2D2D2D2,
              48'hFFFFFFFFFFFF, 48'hD0D0D0D0D0D0};
      src  = {48'h5353535353AA, 48'h5252525252AA,
              48'h123456789ABC, 48'h5050505050AA};
      et   = {16'h86DD, 16'h0806, 16'h0800, 16'h88B5};
      len  = {16'd64, 16'd46, 16'd8, 16'd100};
      #2;
      chk("rst_start", o_start, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_dest", o_dest, 0);
      tick(2);
      rst_n = 1;

      // single requester, field mux and latency
      tick(1);
      req = 4'b0010; en = 1; t0 = cyc;
      wait_start(5, c, ok);
      chk("t1_seen", ok, 1);
      chk("t1_latency", c, t0 + 1);
      chk("t1_ack", o_ack, 4'b0010);
      chk("t1_grant", o_grant, 1);
      chk("t1_dest", o_dest, 48'hFFFFFFFFFFFF);
      chk("t1_src", o_src, 48'h123456789ABC);
      chk("t1_type", o_et, 16'h0800);
      chk("t1_len", o_len, 16'd8);
      tick(1); req = 0;
      tick(4); pulse_done();
      tick(IPG + 3);
      chk("t1_cnt", o_cnt, 1);

      // round robin, all requesting
      do_reset();
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_start(80, c, ok);
         chk("t2_seen", ok, 1);
         st[f] = c; gr[f] = int'(o_grant); fc[f] = int'(o_cnt);
         tick(20); pulse_done();
      end
      req = 0;
      for (int f = 0; f < 5; f++) begin
         chk("t2_order", gr[f], exp_gr[f]);
         chk("t2_cnt", fc[f], f);
         if (f > 0) chk("t2_spacing", st[f] - st[f-1], 20 + IPG + 2);
      end
      tick(IPG + 3);
      chk("t2_final_cnt", o_cnt, 5);

      // spurious done in START and IPG
      do_reset();
      req = 4'b0001; t0 = cyc;
      tick(1); done = 1;
      tick(1); done = 0; req = 0;
      tick(3); pulse_done();
      tick(2); pulse_done();
      req = 4'b0001;
      wait_start(30, c, ok);
      chk("t3_seen", ok, 1);
      chk("t3_restart", c, t0 + 19);
      chk("t3_cnt", o_cnt, 1);
      tick(1); req = 0;
      tick(3); pulse_done();
      tick(IPG + 3);
      chk("t3_cnt2", o_cnt, 2);

      // enable dropped mid-frame
      req = 4'b0001;
      wait_start(10, c, ok);
      chk("t4_seen", ok, 1);
      tick(2); en = 0;
      tick(3); pulse_done();
      nst = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_start) nst++;
      end
      chk("t4_nostart", nst, 0);
      chk("t4_cnt", o_cnt, 3);
      @(posedge clk); #1;
      en = 1; t0 = cyc;
      wait_start(3, c, ok);
      chk("t4_resume", ok && (c - t0 <= 2), 1);

      // async reset mid-BUSY, pointer back to 0
      tick(3);
      #2 rst_n = 0;
      #1;
      chk("t5_start", o_start, 0);
      chk("t5_ack", o_ack, 0);
      chk("t5_busy", o_busy, 0);
      chk("t5_grant", o_grant, 0);
      chk("t5_dest", o_dest, 0);
      chk("t5_cnt", o_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1; req = 4'b1001;
      wait_start(5, c, ok);
      chk("t5_seen", ok, 1);
      chk("t5_rr", o_grant, 0);
      chk("t5_rr_ack", o_ack, 4'b0001);
      tick(1); req = 0;
      tick(2); pulse_done();
      tick(IPG + 3);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
